// File: rtl/oneshot_timer_arbiter_pkg.sv
// oneshot_timer_arbiter_pkg: state encoding shared by the one-shot timer arbiter.
package oneshot_timer_arbiter_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t DONE = 2'd2;

endpackage

// File: rtl/oneshot_timer_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick; search starts just above the last winner.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    // Second pass overrides the wrap-around choice when a requester sits above last.
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--)
            if (req[i]) idx = IW'(i);
        for (int i = N - 1; i >= 0; i--)
            if (req[i] && i > int'(last)) idx = IW'(i);
        gnt = (req != '0) ? (N'(1) << idx) : '0;
    end

endmodule

// File: rtl/oneshot_timer_arbiter.sv
// oneshot_timer_arbiter: one shared down-counting delay timer granted round-robin
// to CHANNELS requesters, returning a one-cycle done pulse to the owner on expiry.
module oneshot_timer_arbiter
    import oneshot_timer_arbiter_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int BITS     = 8,
    parameter int ID_BITS  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     tick,
    input  logic [CHANNELS-1:0]      req,
    input  logic [CHANNELS*BITS-1:0] delay,
    input  logic [CHANNELS-1:0]      abort,
    output logic [CHANNELS-1:0]      ack,
    output logic [CHANNELS-1:0]      done,
    output logic                     busy,
    output logic [ID_BITS-1:0]       grant_id,
    output logic [BITS-1:0]          remaining
);

    state_t                state_q, state_d;
    logic [BITS-1:0]       cnt_q, cnt_d;
    logic [ID_BITS-1:0]    grant_q, grant_d;
    logic [ID_BITS-1:0]    last_q, last_d;
    logic [CHANNELS-1:0]   ack_q, ack_d;
    logic [CHANNELS-1:0]   done_q, done_d;
    logic [CHANNELS-1:0]   win_oh;
    logic [ID_BITS-1:0]    win_idx;
    logic [BITS-1:0]       win_delay;

    rr_arbiter #(.N(CHANNELS), .IW(ID_BITS)) u_arb (
        .req  (req),
        .last (last_q),
        .gnt  (win_oh),
        .idx  (win_idx)
    );

    assign win_delay = delay[win_idx*BITS +: BITS];

    // done is raised on the RUN->DONE edge so it is visible exactly while in DONE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        last_d  = last_q;
        ack_d   = '0;
        done_d  = '0;
        if (state_q == IDLE) begin
            if (req != '0) begin
                cnt_d   = win_delay;
                grant_d = win_idx;
                last_d  = win_idx;
                ack_d   = win_oh;
                state_d = RUN;
            end
        end else if (state_q == RUN) begin
            if (abort[grant_q]) begin
                state_d = IDLE;
            end else if (cnt_q == '0) begin
                state_d = DONE;
                done_d  = CHANNELS'(1) << grant_q;
            end else if (tick) begin
                cnt_d = cnt_q - 1'b1;
            end
        end else begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            grant_q <= '0;
            last_q  <= ID_BITS'(CHANNELS - 1);
            ack_q   <= '0;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
        end
    end

    assign ack       = ack_q;
    assign done      = done_q;
    assign busy      = state_q != IDLE;
    assign grant_id  = grant_q;
    assign remaining = cnt_q;

endmodule

// File: tb/tb_oneshot_timer_arbiter.sv
// tb_oneshot_timer_arbiter: vector table, grant scoreboard and multi-cycle corner sequences.
module tb_oneshot_timer_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        tick = 1'b0;
    logic [3:0]  req = '0;
    logic [31:0] delay = '0;
    logic [3:0]  abort = '0;
    logic [3:0]  ack, done;
    logic        busy;
    logic [1:0]  grant_id;
    logic [7:0]  remaining;

    int total = 0;
    int bad = 0;
    int overlap = 0;
    int multi = 0;

    typedef struct {
        logic [3:0] req;
        logic       tk;
        logic [3:0] ack;
        logic [3:0] done;
        logic       busy;
        logic [7:0] rem;
    } vec_t;

    vec_t tv[6];
    int   q[$];

    oneshot_timer_arbiter #(.CHANNELS(4), .BITS(8), .ID_BITS(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .req       (req),
        .delay     (delay),
        .abort     (abort),
        .ack       (ack),
        .done      (done),
        .busy      (busy),
        .grant_id  (grant_id),
        .remaining (remaining)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst && (ack != '0) && (done != '0)) overlap++;
        if (rst && ($countones(ack) > 1 || $countones(done) > 1)) multi++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        req = '0;
        abort = '0;
        repeat (2) step();
        rst = 1'b1;
        step();
    endtask

    initial begin
        int e, prev;
        tv[0] = '{4'b0001, 1'b1, 4'b0001, 4'b0000, 1'b1, 8'd3};
        tv[1] = '{4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b1, 8'd2};
        tv[2] = '{4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b1, 8'd1};
        tv[3] = '{4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b1, 8'd0};
        tv[4] = '{4'b0000, 1'b1, 4'b0000, 4'b0001, 1'b1, 8'd0};
        tv[5] = '{4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 8'd0};

        do_reset();
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rem", 32'(remaining), 32'd0);
        chk("rst_gid", 32'(grant_id), 32'd0);

        // basic delay of 3 on channel 0
        delay[7:0] = 8'd3;
        for (int i = 0; i < 6; i++) begin
            req = tv[i].req;
            tick = tv[i].tk;
            step();
            chk("vec_ack", 32'(ack), 32'(tv[i].ack));
            chk("vec_done", 32'(done), 32'(tv[i].done));
            chk("vec_busy", 32'(busy), 32'(tv[i].busy));
            chk("vec_rem", 32'(remaining), 32'(tv[i].rem));
        end

        // round robin with all delays zero, grant order 0,1,2,3,0
        do_reset();
        delay = '0;
        tick = 1'b1;
        for (int i = 0; i < 5; i++) q.push_back(i % 4);
        req = 4'hf;
        prev = -1;
        for (int c = 0; c < 40 && q.size() > 0; c++) begin
            step();
            if (ack != '0) begin
                e = q.pop_front();
                chk("rr_ack", 32'(ack), 32'(1) << e);
                chk("rr_gid", 32'(grant_id), 32'(e));
                if (prev >= 0) chk("rr_gap", 32'(c - prev), 32'd3);
                prev = c;
            end
        end
        chk("rr_left", 32'(q.size()), 32'd0);
        req = '0;
        repeat (3) step();
        chk("rr_idle", 32'(busy), 32'd0);

        // channel 1, delay 5, tick every 4th cycle
        delay[15:8] = 8'd5;
        tick = 1'b0;
        req = 4'b0010;
        step();
        chk("sp_ack", 32'(ack), 32'b0010);
        chk("sp_rem0", 32'(remaining), 32'd5);
        req = '0;
        for (int k = 1; k <= 22; k++) begin
            tick = (k % 4 == 0);
            step();
            chk("sp_rem", 32'(remaining), (k <= 20) ? 32'(5 - k / 4) : 32'd0);
            chk("sp_done", 32'(done), (k == 21) ? 32'b0010 : 32'd0);
            chk("sp_busy", 32'(busy), (k <= 21) ? 32'd1 : 32'd0);
        end
        tick = 1'b0;

        // channel 2, delay 10: foreign abort ignored, owner abort at count 6
        delay[23:16] = 8'd10;
        tick = 1'b1;
        req = 4'b0100;
        step();
        chk("ab_ack", 32'(ack), 32'b0100);
        chk("ab_gid", 32'(grant_id), 32'd2);
        req = '0;
        abort = 4'b1000;
        repeat (2) step();
        chk("ab_ign_busy", 32'(busy), 32'd1);
        chk("ab_ign_rem", 32'(remaining), 32'd8);
        abort = '0;
        repeat (2) step();
        chk("ab_rem6", 32'(remaining), 32'd6);
        abort = 4'b0100;
        step();
        abort = '0;
        chk("ab_busy", 32'(busy), 32'd0);
        for (int k = 0; k < 15; k++) begin
            step();
            chk("ab_nodone", 32'(done), 32'd0);
        end

        // reset mid-run clears outputs without a clock edge
        delay[31:24] = 8'd20;
        req = 4'b1000;
        step();
        req = '0;
        repeat (3) step();
        chk("mr_busy_pre", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_rem", 32'(remaining), 32'd0);
        chk("mr_gid", 32'(grant_id), 32'd0);
        chk("mr_ack_done", 32'({ack, done}), 32'd0);
        step();
        rst = 1'b1;
        delay[31:24] = 8'd2;
        req = 4'b1000;
        step();
        chk("mr_ack", 32'(ack), 32'b1000);
        chk("mr_gid3", 32'(grant_id), 32'd3);
        req = '0;
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("mr_done", 32'(done), (k == 3) ? 32'b1000 : 32'd0);
        end

        // delay sampled only at grant
        delay[7:0] = 8'd2;
        req = 4'b0001;
        step();
        chk("dc_ack", 32'(ack), 32'b0001);
        req = '0;
        delay[7:0] = 8'd9;
        for (int k = 1; k <= 4; k++) begin
            step();
            if (k == 1) chk("dc_rem", 32'(remaining), 32'd1);
            chk("dc_done", 32'(done), (k == 3) ? 32'b0001 : 32'd0);
            chk("dc_busy", 32'(busy), (k <= 3) ? 32'd1 : 32'd0);
        end

        chk("ack_done_excl", 32'(overlap), 32'd0);
        chk("onehot", 32'(multi), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
